ps2_line_assembler: RTL and testbench

//   Assembles cleaned PS/2 ASCII keystrokes into fixed-width text lines.

---
 rtl/ps2_line_assembler.sv | 130 +++++++++++++
 tb/tb_ps2_line_assembler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_line_assembler.sv
// Assembles PS/2 keystrokes into fixed-width text lines with backspace/enter editing,
// echoes each edit, and queues finished lines in a small valid/ready FIFO.
module ps2_line_assembler #(
  parameter int                CHAR_W      = 8,
  parameter int                LINE_LEN    = 32,
  parameter int                DEPTH       = 2,
  parameter logic [CHAR_W-1:0] PAD_CHAR    = 8'h20,
  parameter logic [CHAR_W-1:0] ENTER_CODE  = 8'h0D,
  parameter logic [CHAR_W-1:0] BKSP_CODE   = 8'h08,
  parameter bit                ALLOW_EMPTY = 1'b0,
  localparam int               CUR_W       = $clog2(LINE_LEN + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CHAR_W-1:0]          char_in,
  input  logic                       char_valid,
  output logic [LINE_LEN*CHAR_W-1:0] line_out,
  output logic [CUR_W-1:0]           line_length,
  output logic                       line_valid,
  input  logic                       line_ready,
  output logic [CUR_W-1:0]           cursor,
  output logic                       echo_valid,
  output logic [CUR_W-1:0]           echo_col,
  output logic [CHAR_W-1:0]          echo_char,
  output logic                       drop
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDX_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LINE_W = LINE_LEN * CHAR_W;

  logic [CHAR_W-1:0] edit_buf  [LINE_LEN];
  logic [LINE_W-1:0] fifo_data [DEPTH];
  logic [CUR_W-1:0]  fifo_len  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [LINE_W-1:0] packed_buf;
  logic [CUR_W-1:0]  cursor_dec;
  logic              is_enter, is_bksp, is_print;
  logic              commit_req, pop, push;

  // Character 0 lands in the most significant slot of the line bus.
  always_comb begin
    packed_buf = '0;
    for (int i = 0; i < LINE_LEN; i++)
      packed_buf[(LINE_LEN-i)*CHAR_W-1 -: CHAR_W] = edit_buf[i];
  end

  assign is_enter   = char_valid && (char_in == ENTER_CODE);
  assign is_bksp    = char_valid && (char_in == BKSP_CODE);
  assign is_print   = char_valid && !is_enter && !is_bksp;
  assign cursor_dec = cursor - CUR_W'(1);
  assign commit_req = is_enter && ((cursor != '0) || ALLOW_EMPTY);
  assign pop        = line_valid && line_ready;
  // A full FIFO that is popping this cycle still has room for the push.
  assign push       = commit_req && ((count < CNT_W'(DEPTH)) || pop);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Slots are cleared on pop, so the head slot of an empty FIFO reads as padding.
  assign line_out    = fifo_data[rd_ptr];
  assign line_length = fifo_len[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the line storage is reset too, because the empty FIFO and a fresh
      // edit buffer must read back as padding rather than stale text.
      for (int i = 0; i < LINE_LEN; i++) edit_buf[i] <= PAD_CHAR;
      for (int d = 0; d < DEPTH; d++) begin
        fifo_data[d] <= {LINE_LEN{PAD_CHAR}};
        fifo_len[d]  <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      line_valid <= 1'b0;
      cursor     <= '0;
      echo_valid <= 1'b0;
      echo_col   <= '0;
      echo_char  <= '0;
      drop       <= 1'b0;
    end else begin
      // NOTE: every state update here is non-blocking, so later assignments in
      // this block (push after pop on the same slot) override earlier ones
      // without any read-after-write ordering hazard.
      echo_valid <= 1'b0;
      drop       <= 1'b0;

      if (pop) begin
        fifo_data[rd_ptr] <= {LINE_LEN{PAD_CHAR}};
        fifo_len[rd_ptr]  <= '0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end

      if (push) begin
        fifo_data[wr_ptr] <= packed_buf;
        fifo_len[wr_ptr]  <= cursor;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        for (int i = 0; i < LINE_LEN; i++) edit_buf[i] <= PAD_CHAR;
        cursor <= '0;
      end else if (commit_req) begin
        drop <= 1'b1;
      end

      if (is_print) begin
        if (cursor < CUR_W'(LINE_LEN)) begin
          edit_buf[cursor[IDX_W-1:0]] <= char_in;
          cursor     <= cursor + CUR_W'(1);
          echo_valid <= 1'b1;
          echo_col   <= cursor;
          echo_char  <= char_in;
        end else begin
          drop <= 1'b1;
        end
      end

      if (is_bksp && (cursor != '0)) begin
        edit_buf[cursor_dec[IDX_W-1:0]] <= PAD_CHAR;
        cursor     <= cursor_dec;
        echo_valid <= 1'b1;
        echo_col   <= cursor_dec;
        echo_char  <= PAD_CHAR;
      end

      count      <= count_next;
      line_valid <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_ps2_line_assembler.sv
// Bench for ps2_line_assembler: directed scenarios with literal expectations plus
// randomized keystrokes, all compared every cycle against a queue-based line model.
module tb_ps2_line_assembler;

  localparam int LL    = 32;
  localparam int LW    = LL * 8;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    char_in;
  logic          char_valid;
  logic [LW-1:0] line_out;
  logic [5:0]    line_length;
  logic          line_valid;
  logic          line_ready;
  logic [5:0]    cursor;
  logic          echo_valid;
  logic [5:0]    echo_col;
  logic [7:0]    echo_char;
  logic          drop;

  ps2_line_assembler dut (
    .clock(clock), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .line_out(line_out), .line_length(line_length), .line_valid(line_valid),
    .line_ready(line_ready), .cursor(cursor), .echo_valid(echo_valid),
    .echo_col(echo_col), .echo_char(echo_char), .drop(drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [LW-1:0] data;
    int            len;
  } line_t;

  int vectors = 0;
  int miscompares = 0;

  // Model state: plain text buffer, fill count and a queue of committed lines.
  logic [7:0] m_buf [LL];
  int         m_cur;
  line_t      m_q [$];
  logic       m_echo_v, m_drop, m_check_echo;
  int         m_echo_col;
  logic [7:0] m_echo_char;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] pad_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LL; i++) v[(LL-i)*8-1 -: 8] = 8'h20;
    return v;
  endfunction

  function automatic logic [LW-1:0] text_of_buf();
    logic [LW-1:0] v;
    for (int i = 0; i < LL; i++) v[(LL-i)*8-1 -: 8] = m_buf[i];
    return v;
  endfunction

  task automatic model_update(input logic cv, input logic [7:0] c, input logic rdy, input logic rst);
    bit had_room, popping;
    m_echo_v = 1'b0;
    m_drop   = 1'b0;
    m_check_echo = 1'b0;
    if (rst) begin
      foreach (m_buf[i]) m_buf[i] = 8'h20;
      m_cur = 0;
      m_q.delete();
      m_echo_col = 0;
      m_echo_char = 8'h00;
      m_check_echo = 1'b1;
      return;
    end
    popping  = (m_q.size() > 0) && rdy;
    had_room = (m_q.size() < DEPTH) || popping;
    if (popping) void'(m_q.pop_front());
    if (cv) begin
      if (c == 8'h0D) begin
        if (m_cur > 0) begin
          if (had_room) begin
            line_t l;
            l.data = text_of_buf();
            l.len  = m_cur;
            m_q.push_back(l);
            foreach (m_buf[i]) m_buf[i] = 8'h20;
            m_cur = 0;
          end else m_drop = 1'b1;
        end
      end else if (c == 8'h08) begin
        if (m_cur > 0) begin
          m_cur--;
          m_buf[m_cur] = 8'h20;
          m_echo_v = 1'b1; m_echo_col = m_cur; m_echo_char = 8'h20;
        end
      end else if (m_cur < LL) begin
        m_buf[m_cur] = c;
        m_echo_v = 1'b1; m_echo_col = m_cur; m_echo_char = c;
        m_cur++;
      end else m_drop = 1'b1;
    end
    if (m_echo_v) m_check_echo = 1'b1;
  endtask

  task automatic compare_all();
    check("line_valid", line_valid, m_q.size() > 0);
    check("line_out", line_out, (m_q.size() > 0) ? m_q[0].data : pad_line());
    check("line_length", line_length, (m_q.size() > 0) ? m_q[0].len : 0);
    check("cursor", cursor, m_cur);
    check("echo_valid", echo_valid, m_echo_v);
    check("drop", drop, m_drop);
    if (m_check_echo) begin
      check("echo_col", echo_col, m_echo_col);
      check("echo_char", echo_char, m_echo_char);
    end
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic cv, input logic [7:0] c, input logic rdy, input logic rst);
    reset = rst; char_valid = cv; char_in = c; line_ready = rdy;
    @(posedge clock);
    model_update(cv, c, rdy, rst);
    @(negedge clock);
    compare_all();
  endtask

  task automatic key(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, rdy, 1'b0);
  endtask

  logic [LW-1:0] full_pad;

  initial begin
    full_pad = pad_line();
    reset = 1'b1; char_valid = 1'b0; char_in = '0; line_ready = 1'b0;
    @(negedge clock);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_line_out", line_out, full_pad);
    check("reset_valid", line_valid, 1'b0);
    check("reset_echo_col", echo_col, 0);
    check("reset_echo_char", echo_char, 0);

    // 1: commit "ABC"
    key(8'h41); key(8'h42); key(8'h43); key(8'h0D);
    check("t1_valid", line_valid, 1'b1);
    check("t1_head", line_out[LW-1 -: 24], 24'h414243);
    check("t1_tail", line_out[LW-25:0], full_pad[LW-25:0]);
    check("t1_len", line_length, 3);
    check("t1_cursor", cursor, 0);
    idle(1'b1);
    check("t1_drained", line_valid, 1'b0);

    // 2: edit with backspace
    key(8'h58);
    check("t2_echo0", {echo_valid, echo_col, echo_char}, {1'b1, 6'd0, 8'h58});
    key(8'h59);
    check("t2_echo1", {echo_valid, echo_col, echo_char}, {1'b1, 6'd1, 8'h59});
    key(8'h08);
    check("t2_echo2", {echo_valid, echo_col, echo_char}, {1'b1, 6'd1, 8'h20});
    check("t2_cursor", cursor, 1);
    key(8'h0D);
    check("t2_line", line_out[LW-1 -: 16], 16'h5820);
    check("t2_len", line_length, 1);
    idle(1'b1);

    // 3: overflow
    for (int i = 0; i < LL; i++) key(8'h61 + 8'(i % 26));
    key(8'h7A);
    check("t3_drop", drop, 1'b1);
    check("t3_no_echo", echo_valid, 1'b0);
    check("t3_cursor", cursor, 32);
    idle(1'b0);
    check("t3_drop_pulse", drop, 1'b0);
    key(8'h0D);
    check("t3_len", line_length, 32);
    idle(1'b1);

    // 4: FIFO full rejects, retry after pop
    key(8'h41); key(8'h0D); key(8'h42); key(8'h0D);
    key(8'h43); key(8'h0D);
    check("t4_drop", drop, 1'b1);
    check("t4_cursor", cursor, 1);
    idle(1'b1);
    check("t4_head_b", line_out[LW-1 -: 8], 8'h42);
    key(8'h0D);
    check("t4_accept", cursor, 0);
    check("t4_no_drop", drop, 1'b0);

    // 5: push into full FIFO while popping
    key(8'h44);
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    check("t5_accept", cursor, 0);
    check("t5_valid", line_valid, 1'b1);
    check("t5_head_c", line_out[LW-1 -: 8], 8'h43);
    idle(1'b1);
    check("t5_head_d", line_out[LW-1 -: 8], 8'h44);
    idle(1'b1);

    // 6: reset mid-line with a queued line
    key(8'h51); key(8'h0D);
    for (int i = 0; i < 5; i++) key(8'h30 + 8'(i));
    check("t6_pre_cursor", cursor, 5);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t6_cursor", cursor, 0);
    check("t6_valid", line_valid, 1'b0);
    check("t6_line", line_out, full_pad);
    key(8'h08);
    check("t6_bksp", {echo_valid, drop}, 2'b00);

    // Randomized traffic in phases with different consumer readiness.
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] c;
      logic cv, rdy, rst;
      r = int'($urandom_range(99));
      if (r < 6) c = 8'h0D;
      else if (r < 16) c = 8'h08;
      else c = 8'($urandom_range(255));
      cv  = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < (((n / 500) % 2 == 0) ? 15 : 70));
      rst = ($urandom_range(999) < 4);
      step(cv, c, rdy, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
